// File: rtl/mole_pkg.sv
// ---------------------------------------------------------------------------
// mole_pkg
// Shared types and constants for the mole scheduler slice.
//   state_t    : scheduler FSM states {IDLE, GAP, SPAWN, UP}
//   LFSR_TAPS  : Galois feedback mask for the 16-bit hole-picking LFSR
//   ROUND_W    : width of the cleared-round counter
//   TICK_W     : width of tick counters and the up-window register
//   lfsrNext() : one right-shifting Galois step of the LFSR
// ---------------------------------------------------------------------------
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SPAWN,
    UP
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          ROUND_W   = 8;
  localparam int          TICK_W    = 16;

  // The bit shifted out of the bottom decides whether the taps are folded in.
  function automatic logic [15:0] lfsrNext(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/mole_scheduler_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Galois LFSR used as the random source for hole picks.
// It advances on every clock, whatever the scheduler is doing.
// Ports:
//   clk   in   1   system clock
//   reset in   1   synchronous, active-high; loads the seed
//   seed  in  16   reset value; an all-zero seed is replaced by 16'h0001
//   q     out 16   current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
  import mole_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;

  // An all-zero state would lock the LFSR forever, so a zero seed is swapped
  // for the smallest legal state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else begin
      r_q <= lfsrNext(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mole_scheduler.sv
// ---------------------------------------------------------------------------
// mole_scheduler
// Raises moles for hit_logic: after a quiet gap it picks random hole(s),
// holds them up for a timed window and drops them, either on a full clear
// from hit_logic or on expiry. Each clear shortens the window down to a floor.
// Optional feature macro: DOUBLE_MOLE_EN (two-mole rounds after 4 clears).
// Ports:
//   clk              in   1          system clock
//   reset            in   1          synchronous, active-high
//   game_in_progress in   1          level; low forces IDLE
//   full_clear_hit   in   1          pulse: every raised mole was hit
//   mole_positions   out  NUM_HOLES  1 = mole up in that hole
//   timeout_pulse    out  1          pulse: window expired without a clear
//   round_count      out  8          cleared rounds this game, saturating
//   up_ticks         out  16         current up-window length in ticks
// ---------------------------------------------------------------------------
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int          NUM_HOLES     = 6,
  parameter int          CLKS_PER_TICK = 50000,
  parameter int          GAP_TICKS     = 300,
  parameter int          UP_TIME_TICKS = 1500,
  parameter int          UP_STEP_TICKS = 50,
  parameter int          MIN_UP_TICKS  = 400,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 game_in_progress,
  input  logic                 full_clear_hit,
  output logic [NUM_HOLES-1:0] mole_positions,
  output logic                 timeout_pulse,
  output logic [ROUND_W-1:0]   round_count,
  output logic [TICK_W-1:0]    up_ticks
);

  localparam int PRESC_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int SUM_W   = TICK_W + 1;

  state_t                r_state;
  logic [PRESC_W-1:0]    r_presc;
  logic [TICK_W-1:0]     r_tickCnt;
  logic [NUM_HOLES-1:0]  r_moles;
  logic                  r_timeout;
  logic [ROUND_W-1:0]    r_roundCount;
  logic [TICK_W-1:0]     r_upTicks;

  logic [15:0]           w_lfsr;
  logic                  w_tick;
  logic                  w_gapDone;
  logic                  w_upDone;
  logic [TICK_W-1:0]     w_upNext;
  logic [7:0]            w_ia;
  logic [NUM_HOLES-1:0]  w_spawnMask;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (w_lfsr)
  );

  // A tick fires on the last prescaler cycle; a state lasting N ticks leaves
  // on the tick where the counter still reads N-1, i.e. N*CLKS_PER_TICK
  // cycles after entry.
  assign w_tick    = (r_presc == PRESC_W'(CLKS_PER_TICK - 1));
  assign w_gapDone = w_tick && (r_tickCnt == TICK_W'(GAP_TICKS - 1));
  assign w_upDone  = w_tick && (r_tickCnt == (r_upTicks - TICK_W'(1)));

  // Shrink the window but never below the floor; the compare is done one bit
  // wider so the subtraction can never wrap.
  assign w_upNext = ({1'b0, r_upTicks} >= (SUM_W'(MIN_UP_TICKS) + SUM_W'(UP_STEP_TICKS)))
                    ? (r_upTicks - TICK_W'(UP_STEP_TICKS))
                    : TICK_W'(MIN_UP_TICKS);

  assign w_ia = w_lfsr[7:0] % 8'(NUM_HOLES);

`ifdef DOUBLE_MOLE_EN
  logic [7:0] w_ib;
  logic       w_dbl;

  // The second hole is offset by 1..NUM_HOLES-1 from the first, so it can
  // never land on the same hole.
  assign w_ib  = (w_ia + 8'd1 + (w_lfsr[15:8] % 8'(NUM_HOLES - 1))) % 8'(NUM_HOLES);
  assign w_dbl = w_lfsr[0] && (r_roundCount >= ROUND_W'(4));
  assign w_spawnMask = (NUM_HOLES'(1) << w_ia) | (w_dbl ? (NUM_HOLES'(1) << w_ib) : '0);
`else
  logic w_unusedLfsr;

  assign w_unusedLfsr = ^w_lfsr[15:8];
  assign w_spawnMask  = NUM_HOLES'(1) << w_ia;
`endif

  // Scheduler FSM with registered outputs. Losing game_in_progress beats
  // everything; inside UP a clear beats an expiry landing on the same cycle.
  // Every state change clears the prescaler and tick counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_tickCnt    <= '0;
      r_moles      <= '0;
      r_timeout    <= 1'b0;
      r_roundCount <= '0;
      r_upTicks    <= TICK_W'(UP_TIME_TICKS);
    end else begin
      r_timeout <= 1'b0;
      if (w_tick) begin
        r_presc   <= '0;
        r_tickCnt <= r_tickCnt + TICK_W'(1);
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end

      if (!game_in_progress) begin
        r_state   <= IDLE;
        r_moles   <= '0;
        r_presc   <= '0;
        r_tickCnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state      <= GAP;
            r_moles      <= '0;
            r_roundCount <= '0;
            r_upTicks    <= TICK_W'(UP_TIME_TICKS);
            r_presc      <= '0;
            r_tickCnt    <= '0;
          end
          GAP: begin
            r_moles <= '0;
            if (w_gapDone) begin
              r_state   <= SPAWN;
              r_presc   <= '0;
              r_tickCnt <= '0;
            end
          end
          SPAWN: begin
            r_state   <= UP;
            r_moles   <= w_spawnMask;
            r_presc   <= '0;
            r_tickCnt <= '0;
          end
          UP: begin
            if (full_clear_hit) begin
              r_state   <= GAP;
              r_moles   <= '0;
              r_upTicks <= w_upNext;
              r_presc   <= '0;
              r_tickCnt <= '0;
              if (r_roundCount != {ROUND_W{1'b1}}) begin
                r_roundCount <= r_roundCount + ROUND_W'(1);
              end
            end else if (w_upDone) begin
              r_state   <= GAP;
              r_moles   <= '0;
              r_timeout <= 1'b1;
              r_presc   <= '0;
              r_tickCnt <= '0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_moles <= '0;
          end
        endcase
      end
    end
  end

  assign mole_positions = r_moles;
  assign timeout_pulse  = r_timeout;
  assign round_count    = r_roundCount;
  assign up_ticks       = r_upTicks;

endmodule

// File: tb/tb_mole_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mole_scheduler
// Self-checking bench for mole_scheduler with a short tick (2 clocks), a
// 3-tick gap and a 5-tick initial window stepping down by 1 to a floor of 3.
// Expected values are queued when stimulus is applied and popped when the
// DUT responds; hole picks are predicted from an independent LFSR model.
// ---------------------------------------------------------------------------
module tb_mole_scheduler;

  localparam int NH = 6;

  typedef struct {
    string       tag;
    int unsigned val;
  } expEntry_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          gip = 1'b0;
  logic          hit = 1'b0;
  logic [NH-1:0] mole;
  logic          tp;
  logic [7:0]    rc;
  logic [15:0]   ut;

  int            compared = 0;
  int            mismatched = 0;
  expEntry_t     sbQ[$];

  logic [15:0]   mLfsr;
  logic [15:0]   mPrev;
  int            expRound;
  int            expUp;
  logic [NH-1:0] seenMask;

  mole_scheduler #(
    .NUM_HOLES     (NH),
    .CLKS_PER_TICK (2),
    .GAP_TICKS     (3),
    .UP_TIME_TICKS (5),
    .UP_STEP_TICKS (1),
    .MIN_UP_TICKS  (3),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .game_in_progress (gip),
    .full_clear_hit   (hit),
    .mole_positions   (mole),
    .timeout_pulse    (tp),
    .round_count      (rc),
    .up_ticks         (ut)
  );

  always #5 clk = ~clk;

  // Reference LFSR; mPrev holds the value one clock back, which is what the
  // DUT saw during its SPAWN cycle when a new mole pattern first appears.
  always @(posedge clk) begin
    if (reset) begin
      mLfsr <= 16'hACE1;
    end else begin
      mLfsr <= {1'b0, mLfsr[15:1]} ^ (mLfsr[0] ? 16'hB400 : 16'h0000);
    end
    mPrev <= mLfsr;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int unsigned obs, input int unsigned exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expectPush(input string tag, input int unsigned val);
    expEntry_t e;
    e.tag = tag;
    e.val = val;
    sbQ.push_back(e);
  endtask

  task automatic popCheck(input int unsigned obs);
    expEntry_t e;
    if (sbQ.size() == 0) begin
      checkOutput("sbEmpty", 1, 0);
    end else begin
      e = sbQ.pop_front();
      checkOutput(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the inputs for one clock; hit is a single-cycle pulse.
  task automatic applyStimulus(input logic g, input logic h);
    gip = g;
    hit = h;
    tick();
    hit = 1'b0;
  endtask

  task automatic waitMole(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (mole == '0 && cycles < 100);
  endtask

  task automatic waitDrop(output int cycles, output logic sawTo);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (mole != '0 && cycles < 100);
    sawTo = tp;
  endtask

  function automatic logic [NH-1:0] expMask(input logic [15:0] l, input logic allowDbl);
    int            ia;
    int            ib;
    logic [NH-1:0] m;
    ia = int'(l[7:0]) % NH;
    ib = (ia + 1 + int'(l[15:8]) % (NH - 1)) % NH;
    m = '0;
    m[ia] = 1'b1;
    if (allowDbl && l[0]) m[ib] = 1'b1;
    return m;
  endfunction

  function automatic logic dblAllowed(input int rnd);
`ifdef DOUBLE_MOLE_EN
    return (rnd >= 4);
`else
    return (rnd < 0);
`endif
  endfunction

  // Check the freshly raised pattern against the model, then clear it after
  // holdCycles more cycles and verify the round bookkeeping.
  task automatic doClear(input int expLat, input int holdCycles);
    int lat;
    expectPush("spawnLat", expLat);
    waitMole(lat);
    popCheck(lat);
    checkOutput("mask", mole, expMask(mPrev, dblAllowed(expRound)));
`ifdef DOUBLE_MOLE_EN
    checkOutput("popRange", ($countones(mole) == 1) || ($countones(mole) == 2 && expRound >= 4), 1);
`else
    checkOutput("popOne", $countones(mole), 1);
`endif
    seenMask |= mole;
    repeat (holdCycles) tick();
    checkOutput("stillUp", (mole != '0), 1);
    if (expRound < 255) expRound++;
    expUp = (expUp - 1 < 3) ? 3 : expUp - 1;
    expectPush("hitMole", 0);
    expectPush("hitTo", 0);
    expectPush("hitRound", expRound);
    expectPush("hitUp", expUp);
    applyStimulus(1'b1, 1'b1);
    popCheck(mole);
    popCheck(tp);
    popCheck(rc);
    popCheck(ut);
  endtask

  initial begin
    int   lat;
    int   bad;
    logic sawTo;

    seenMask = '0;

    // Reset and idle behaviour
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("rstMole", mole, 0);
    checkOutput("rstTo", tp, 0);
    checkOutput("rstRound", rc, 0);
    checkOutput("rstUp", ut, 5);
    reset = 1'b0;
    bad = 0;
    repeat (8) begin
      tick();
      if (mole != '0 || tp) bad++;
    end
    checkOutput("idleQuiet", bad, 0);

    // First round left to time out
    expRound = 0;
    expUp = 5;
    expectPush("startLat", 8);
    gip = 1'b1;
    waitMole(lat);
    popCheck(lat);
    checkOutput("firstMask", mole, expMask(mPrev, 1'b0));
    checkOutput("firstOneHot", $countones(mole), 1);
    expectPush("upLen", 10);
    expectPush("toPulse", 1);
    waitDrop(lat, sawTo);
    popCheck(lat);
    popCheck(sawTo);
    checkOutput("toRound", rc, 0);
    checkOutput("toUp", ut, 5);
    tick();
    checkOutput("toWidth", tp, 0);

    // Clears shorten the window down to the floor
    doClear(6, 1);
    doClear(7, 2);
    doClear(7, 0);
    checkOutput("upFloor", ut, 3);

    // Clear landing exactly on the expiry cycle (window is 6 cycles now)
    doClear(7, 5);
    checkOutput("expiryRound", rc, 4);

    // Clear pulse during GAP must be ignored
    applyStimulus(1'b1, 1'b1);
    checkOutput("strayRound", rc, 4);
    checkOutput("strayUp", ut, 3);

    // Drop the game mid-UP, then restart
    expectPush("strayLat", 6);
    waitMole(lat);
    popCheck(lat);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("abortMole", mole, 0);
    checkOutput("abortTo", tp, 0);
    checkOutput("abortRound", rc, 4);
    checkOutput("abortUp", ut, 3);
    bad = 0;
    repeat (15) begin
      tick();
      if (mole != '0 || tp) bad++;
    end
    checkOutput("abortQuiet", bad, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("restartRound", rc, 0);
    checkOutput("restartUp", ut, 5);
    expRound = 0;
    expUp = 5;

    // Long run of clears, through round-count saturation
    for (int r = 0; r < 260; r++) begin
      doClear(7, $urandom_range(0, 2 * expUp - 1));
    end
    checkOutput("roundSat", rc, 255);
    checkOutput("allHoles", seenMask, {NH{1'b1}});

    // Reset in the middle of a round
    expectPush("preRstLat", 7);
    waitMole(lat);
    popCheck(lat);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midRstMole", mole, 0);
    checkOutput("midRstRound", rc, 0);
    checkOutput("midRstUp", ut, 5);
    checkOutput("midRstTo", tp, 0);
    expRound = 0;
    expUp = 5;
    expectPush("postRstLat", 8);
    waitMole(lat);
    popCheck(lat);
    checkOutput("postRstMask", mole, expMask(mPrev, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
